// File: rtl/stack_engine.sv
// Parametrised downward-growing hardware stack with registered top-of-stack, occupancy count and sticky error flags.
// Optional high-water-mark output `hwm` is enabled by defining STACK_ENGINE_WATERMARK_EN.
module stack_engine #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 16,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              clear,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [PTR_W-1:0]  sp,
  output logic [PTR_W:0]    count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
`ifdef STACK_ENGINE_WATERMARK_EN
  ,
  output logic [PTR_W:0]    hwm
`endif
);

  localparam logic [PTR_W-1:0]  SP_INIT    = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0]  SP_ONE     = PTR_W'(1);
  localparam logic [PTR_W-1:0]  SP_TWO     = PTR_W'(2);
  localparam logic [PTR_W:0]    CNT_ZERO   = '0;
  localparam logic [PTR_W:0]    CNT_ONE    = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]    CNT_TWO    = (PTR_W + 1)'(2);
  localparam logic [PTR_W:0]    CNT_FULL   = (PTR_W + 1)'(DEPTH);
  localparam logic [DATA_W-1:0] DATA_ZERO  = '0;

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_CLEAR,
    OP_PUSH,
    OP_POP,
    OP_REPLACE,
    OP_OVERFLOW,
    OP_UNDERFLOW
  } op_e;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0]  sp_q, sp_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic [PTR_W-1:0]  sp_plus1, sp_plus2;
  logic [DATA_W-1:0] next_top;
  logic              is_empty, is_full;
  logic              wr_en;
  logic [PTR_W-1:0]  wr_addr;
  op_e               op;

  assign is_empty = (count_q == CNT_ZERO);
  assign is_full  = (count_q == CNT_FULL);
  assign sp_plus1 = sp_q + SP_ONE;
  assign sp_plus2 = sp_q + SP_TWO;
  // Entry that becomes the top after a pop; only meaningful when count >= 2.
  assign next_top = mem[sp_plus2];

  always_comb begin
    op = OP_IDLE;
    if (clear) begin
      op = OP_CLEAR;
    end else begin
      case ({push, pop})
        2'b10:   op = is_full  ? OP_OVERFLOW  : OP_PUSH;
        2'b01:   op = is_empty ? OP_UNDERFLOW : OP_POP;
        2'b11:   op = is_empty ? OP_PUSH      : OP_REPLACE;
        default: op = OP_IDLE;
      endcase
    end
  end

  always_comb begin
    sp_d        = sp_q;
    count_d     = count_q;
    dout_d      = dout_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    wr_en       = 1'b0;
    wr_addr     = sp_q;
    case (op)
      OP_CLEAR: begin
        sp_d    = SP_INIT;
        count_d = CNT_ZERO;
        dout_d  = DATA_ZERO;
      end
      OP_PUSH: begin
        wr_en   = 1'b1;
        wr_addr = sp_q;
        sp_d    = sp_q - SP_ONE;
        count_d = count_q + CNT_ONE;
        dout_d  = din;
      end
      OP_POP: begin
        sp_d    = sp_plus1;
        count_d = count_q - CNT_ONE;
        dout_d  = (count_q >= CNT_TWO) ? next_top : DATA_ZERO;
      end
      OP_REPLACE: begin
        wr_en   = 1'b1;
        wr_addr = sp_plus1;
        dout_d  = din;
      end
      OP_OVERFLOW:  overflow_d  = 1'b1;
      OP_UNDERFLOW: underflow_d = 1'b1;
      default: begin
      end
    endcase
  end

  // Storage has no reset; a reset cycle must not disturb it either.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[wr_addr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q        <= SP_INIT;
      count_q     <= CNT_ZERO;
      dout_q      <= DATA_ZERO;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      sp_q        <= sp_d;
      count_q     <= count_d;
      dout_q      <= dout_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef STACK_ENGINE_WATERMARK_EN
  logic [PTR_W:0] hwm_q;

  // Tracks the registered count, so the mark lags a new peak by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      hwm_q <= CNT_ZERO;
    end else if (count_q > hwm_q) begin
      hwm_q <= count_q;
    end
  end

  assign hwm = hwm_q;
`endif

  assign dout      = dout_q;
  assign sp        = sp_q;
  assign count     = count_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_stack_engine.sv
// Directed self-checking bench for stack_engine at the default 8-bit x 16-entry configuration.
// The hwm scenario is compiled only when STACK_ENGINE_WATERMARK_EN is defined.
module tb_stack_engine;

  logic       clk;
  logic       rst;
  logic       push;
  logic       pop;
  logic       clear;
  logic [7:0] din;
  logic [7:0] dout;
  logic [3:0] sp;
  logic [4:0] count;
  logic       empty;
  logic       full;
  logic       overflow;
  logic       underflow;
`ifdef STACK_ENGINE_WATERMARK_EN
  logic [4:0] hwm;
`endif

  int total = 0;
  int bad   = 0;

  stack_engine #(.DATA_W(8), .DEPTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .clear     (clear),
    .din       (din),
    .dout      (dout),
    .sp        (sp),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
`ifdef STACK_ENGINE_WATERMARK_EN
    ,
    .hwm       (hwm)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one cycle of strobes, then returns 1 ns after the edge with strobes dropped.
  task automatic step(input logic p, input logic po, input logic c, input logic r, input logic [7:0] d);
    push = p; pop = po; clear = c; rst = r; din = d;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; clear = 1'b0; rst = 1'b0;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
  endtask

  task automatic test_reset();
    do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    total++; if (sp !== 4'd15) begin bad++; $display("[TB] FAIL reset_sp: got %0d want 15", sp); end
    total++; if (count !== 5'd0) begin bad++; $display("[TB] FAIL reset_count: got %0d want 0", count); end
    total++; if (dout !== 8'h00) begin bad++; $display("[TB] FAIL reset_dout: got %h want 00", dout); end
    total++; if ({empty, full, overflow, underflow} !== 4'b1000) begin bad++;
      $display("[TB] FAIL reset_flags: got e/f/o/u=%b want 1000", {empty, full, overflow, underflow}); end
  endtask

  task automatic test_push_pop();
    logic [7:0] exp_pop [3];
    exp_pop[0] = 8'h22; exp_pop[1] = 8'h11; exp_pop[2] = 8'h00;
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h11);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h22);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h33);
    total++; if (dout !== 8'h33) begin bad++; $display("[TB] FAIL push3_dout: got %h want 33", dout); end
    total++; if (count !== 5'd3) begin bad++; $display("[TB] FAIL push3_count: got %0d want 3", count); end
    total++; if (sp !== 4'd12) begin bad++; $display("[TB] FAIL push3_sp: got %0d want 12", sp); end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      total++; if (dout !== exp_pop[i]) begin bad++;
        $display("[TB] FAIL pop%0d_dout: got %h want %h", i, dout, exp_pop[i]); end
    end
    total++; if (count !== 5'd0 || empty !== 1'b1) begin bad++;
      $display("[TB] FAIL pop_all_empty: got count=%0d empty=%b want 0/1", count, empty); end
    total++; if (underflow !== 1'b0 || sp !== 4'd15) begin bad++;
      $display("[TB] FAIL pop_all_state: got underflow=%b sp=%0d want 0/15", underflow, sp); end
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'(i));
    total++; if (full !== 1'b1 || count !== 5'd16) begin bad++;
      $display("[TB] FAIL fill_full: got full=%b count=%0d want 1/16", full, count); end
    total++; if (sp !== 4'd15) begin bad++; $display("[TB] FAIL fill_sp_wrap: got %0d want 15", sp); end
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'hAA);
    total++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_flag: got %b want 1", overflow); end
    total++; if (count !== 5'd16 || dout !== 8'h0F) begin bad++;
      $display("[TB] FAIL ovf_dropped: got count=%0d dout=%h want 16/0f", count, dout); end
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    total++; if (dout !== 8'h0E || count !== 5'd15) begin bad++;
      $display("[TB] FAIL ovf_then_pop: got dout=%h count=%0d want 0e/15", dout, count); end
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    total++; if (overflow !== 1'b1 || count !== 5'd0 || sp !== 4'd15 || dout !== 8'h00) begin bad++;
      $display("[TB] FAIL clear_keeps_ovf: got ovf=%b count=%0d sp=%0d dout=%h want 1/0/15/00",
               overflow, count, sp, dout); end
  endtask

  task automatic test_full_replace();
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'(i));
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'hBB);
    total++; if (dout !== 8'hBB || count !== 5'd16 || overflow !== 1'b0) begin bad++;
      $display("[TB] FAIL full_replace: got dout=%h count=%0d ovf=%b want bb/16/0", dout, count, overflow); end
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    total++; if (dout !== 8'h0E) begin bad++; $display("[TB] FAIL full_replace_pop: got %h want 0e", dout); end
  endtask

  task automatic test_underflow_clear();
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    total++; if (underflow !== 1'b1 || count !== 5'd0 || dout !== 8'h00) begin bad++;
      $display("[TB] FAIL unf_flag: got unf=%b count=%0d dout=%h want 1/0/00", underflow, count, dout); end
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    total++; if (underflow !== 1'b1) begin bad++; $display("[TB] FAIL unf_after_clear: got %b want 1", underflow); end
    do_reset();
    total++; if (underflow !== 1'b0) begin bad++; $display("[TB] FAIL unf_after_rst: got %b want 0", underflow); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h05);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h06);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h77);
    total++; if (dout !== 8'h77 || count !== 5'd2 || sp !== 4'd13) begin bad++;
      $display("[TB] FAIL replace: got dout=%h count=%0d sp=%0d want 77/2/13", dout, count, sp); end
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    total++; if (dout !== 8'h05 || count !== 5'd1) begin bad++;
      $display("[TB] FAIL replace_pop: got dout=%h count=%0d want 05/1", dout, count); end
    do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h09);
    total++; if (count !== 5'd1 || dout !== 8'h09 || underflow !== 1'b0 || sp !== 4'd14) begin bad++;
      $display("[TB] FAIL both_empty: got count=%0d dout=%h unf=%b sp=%0d want 1/09/0/14",
               count, dout, underflow, sp); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'hA1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'hA2);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'hA3);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    total++; if (dout !== 8'hA2 || count !== 5'd1 || sp !== 4'd14) begin bad++;
      $display("[TB] FAIL b2b: got dout=%h count=%0d sp=%0d want a2/1/14", dout, count, sp); end
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'hCC);
    total++; if (count !== 5'd0 || dout !== 8'h00) begin bad++;
      $display("[TB] FAIL clear_over_push: got count=%0d dout=%h want 0/00", count, dout); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h44);
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'h55);
    total++; if (count !== 5'd0 || dout !== 8'h00 || sp !== 4'd15) begin bad++;
      $display("[TB] FAIL rst_mid: got count=%0d dout=%h sp=%0d want 0/00/15", count, dout, sp); end
  endtask

`ifdef STACK_ENGINE_WATERMARK_EN
  task automatic test_watermark();
    do_reset();
    total++; if (hwm !== 5'd0) begin bad++; $display("[TB] FAIL hwm_reset: got %0d want 0", hwm); end
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'(i + 1));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h66);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    total++; if (hwm !== 5'd5) begin bad++; $display("[TB] FAIL hwm_peak: got %0d want 5", hwm); end
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    total++; if (hwm !== 5'd5) begin bad++; $display("[TB] FAIL hwm_after_clear: got %0d want 5", hwm); end
  endtask
`endif

  initial begin
    rst = 1'b0; push = 1'b0; pop = 1'b0; clear = 1'b0; din = 8'h00;
    test_reset();
    test_push_pop();
    test_fill_overflow();
    test_full_replace();
    test_underflow_clear();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
`ifdef STACK_ENGINE_WATERMARK_EN
    test_watermark();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
